// File: rtl/regfile_port_scheduler.sv
// Arbitrates the single-ported 32x32 register file between one dual-operand read
// requester and NWR write-back requesters; one file operation is granted per cycle.
module regfile_port_scheduler #(
  parameter int NWR        = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NWR-1:0]        wr_valid,
  input  logic [NWR*5-1:0]      wr_addr,
  input  logic [NWR*32-1:0]     wr_data,
  output logic [NWR-1:0]        wr_ready,
  input  logic                  rd_valid,
  input  logic [4:0]            rd_a1,
  input  logic [4:0]            rd_a2,
  output logic                  rd_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rd1,
  output logic [31:0]           rsp_rd2,
  output logic                  rf_we3,
  output logic [4:0]            rf_a1,
  output logic [4:0]            rf_a2,
  output logic [4:0]            rf_a3,
  output logic [31:0]           rf_wd3,
  input  logic [31:0]           rf_rd1,
  input  logic [31:0]           rf_rd2,
  output logic                  dbg_mode,
  output logic [$clog2(NWR)-1:0]          dbg_rr_ptr,
  output logic [$clog2(STARVE_MAX+1)-1:0] dbg_starve_cnt
);

  localparam int PW = $clog2(NWR);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [PW:0]   NWR_W = (PW+1)'(NWR);
  localparam logic [CW-1:0] SMAX  = CW'(STARVE_MAX);

  // Handshake: a transfer happens in any cycle where valid and ready are both
  // high; ready is combinational from this cycle's requests and never waits on it.

  typedef enum logic {RD_PRI, WR_FORCE} mode_t;

  mode_t          mode, mode_next;
  logic [PW-1:0]  rr_ptr, rr_next;
  logic [CW-1:0]  starve_cnt, cnt_next;
  logic           rsp_q;

  logic [NWR-1:0] rot;
  logic           found;
  logic [PW:0]    off;
  logic [PW:0]    sum;
  logic [PW:0]    nxt;
  logic [PW-1:0]  win_idx;
  logic [4:0]     sel_addr;
  logic [31:0]    sel_data;
  logic           do_wr;
  logic           do_rd;

  // Rotate so that bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    rot   = NWR'({wr_valid, wr_valid} >> rr_ptr);
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NWR; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = (PW+1)'(k);
      end
    end
    sum     = {1'b0, rr_ptr} + off;
    win_idx = (sum >= NWR_W) ? PW'(sum - NWR_W) : PW'(sum);
    nxt     = {1'b0, win_idx} + (PW+1)'(1);
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NWR; i++) begin
      if (win_idx == PW'(i)) begin
        sel_addr = wr_addr[i*5 +: 5];
        sel_data = wr_data[i*32 +: 32];
      end
    end
  end

  // A forced cycle with nothing to write is spent idle before reads resume.
  always_comb begin
    do_wr = 1'b0;
    do_rd = 1'b0;
    if (!reset) begin
      if (mode == WR_FORCE) begin
        do_wr = found;
      end else begin
        do_wr = found && !rd_valid;
        do_rd = rd_valid;
      end
    end
  end

  always_comb begin
    mode_next = mode;
    rr_next   = rr_ptr;
    cnt_next  = starve_cnt;
    if (do_wr) rr_next = (nxt == NWR_W) ? '0 : PW'(nxt);
    if (do_wr || !found) cnt_next = '0;
    else if (do_rd && starve_cnt != SMAX) cnt_next = starve_cnt + CW'(1);
    if (mode == WR_FORCE) mode_next = RD_PRI;
    else if (cnt_next == SMAX) mode_next = WR_FORCE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode       <= RD_PRI;
      rr_ptr     <= '0;
      starve_cnt <= '0;
      rsp_q      <= 1'b0;
    end else begin
      mode       <= mode_next;
      rr_ptr     <= rr_next;
      starve_cnt <= cnt_next;
      rsp_q      <= do_rd;
    end
  end

  always_comb begin
    wr_ready = '0;
    for (int i = 0; i < NWR; i++) wr_ready[i] = do_wr && (win_idx == PW'(i));
  end

  assign rd_ready  = do_rd;
  assign rf_a1     = do_rd ? rd_a1 : 5'd0;
  assign rf_a2     = do_rd ? rd_a2 : 5'd0;
  assign rf_a3     = do_wr ? sel_addr : 5'd0;
  assign rf_wd3    = do_wr ? sel_data : 32'd0;
  // r0 is hardwired zero: the write is acknowledged but never reaches the file.
  assign rf_we3    = do_wr && (sel_addr != 5'd0);

  assign rsp_valid = rsp_q;
  assign rsp_rd1   = rf_rd1;
  assign rsp_rd2   = rf_rd2;

  assign dbg_mode       = (mode == WR_FORCE);
  assign dbg_rr_ptr     = rr_ptr;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Bench for regfile_port_scheduler: grant-pattern vector table, hand-written
// corner sequences, and a read-data scoreboard backed by a register-file model.
module tb_regfile_port_scheduler;

  localparam int NWR = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NWR-1:0]    wr_valid = '0;
  logic [NWR*5-1:0]  wr_addr = '0;
  logic [NWR*32-1:0] wr_data = '0;
  logic [NWR-1:0]    wr_ready;
  logic              rd_valid = 1'b0;
  logic [4:0]        rd_a1 = '0;
  logic [4:0]        rd_a2 = '0;
  logic              rd_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_rd1, rsp_rd2;
  logic              rf_we3;
  logic [4:0]        rf_a1, rf_a2, rf_a3;
  logic [31:0]       rf_wd3;
  logic [31:0]       rf_rd1 = '0;
  logic [31:0]       rf_rd2 = '0;
  logic              dbg_mode;
  logic [1:0]        dbg_rr_ptr;
  logic [2:0]        dbg_starve_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] rf_mem [32] = '{default: '0};
  logic [31:0] gold   [32] = '{default: '0};

  regfile_port_scheduler #(.NWR(NWR), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2),
    .rf_we3(rf_we3), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .dbg_mode(dbg_mode), .dbg_rr_ptr(dbg_rr_ptr), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Register file model: registered dual read, single write port.
  always @(posedge clk) begin
    if (rf_we3) rf_mem[rf_a3] <= rf_wd3;
    rf_rd1 <= rf_mem[rf_a1];
    rf_rd2 <= rf_mem[rf_a2];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [NWR-1:0] wv, input logic rv);
    wr_valid = wv;
    rd_valid = rv;
    for (int i = 0; i < NWR; i++) begin
      wr_addr[i*5 +: 5]   = 5'($urandom_range(31, 1));
      wr_data[i*32 +: 32] = $urandom;
    end
    rd_a1 = 5'($urandom_range(31, 0));
    rd_a2 = 5'($urandom_range(31, 0));
  endtask

  task automatic set_wr(input int i, input logic [4:0] a, input logic [31:0] d);
    wr_addr[i*5 +: 5]   = a;
    wr_data[i*32 +: 32] = d;
  endtask

  // Scoreboard: read data expected exactly one cycle after each read handshake.
  initial begin
    logic rsp_due;
    logic [63:0] exp_v;
    rsp_due = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        exp_q.delete();
        rsp_due = 1'b0;
      end else begin
        check("rsp_valid_timing", rsp_valid, rsp_due);
        if (rsp_valid && rsp_due && exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check("rsp_data", {rsp_rd1, rsp_rd2}, exp_v);
        end
        rsp_due = rd_valid && rd_ready;
        if (rsp_due) exp_q.push_back({gold[rd_a1], gold[rd_a2]});
        for (int i = 0; i < NWR; i++) begin
          if (wr_valid[i] && wr_ready[i] && wr_addr[i*5 +: 5] != 5'd0)
            gold[wr_addr[i*5 +: 5]] = wr_data[i*32 +: 32];
        end
      end
    end
  end

  typedef struct {
    logic [NWR-1:0] wv;
    logic           rv;
    logic [NWR-1:0] exp_wr;
    logic           exp_rd;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{3'b000, 1'b1, 3'b000, 1'b1};
    vecs[1]  = '{3'b111, 1'b0, 3'b001, 1'b0};
    vecs[2]  = '{3'b111, 1'b0, 3'b010, 1'b0};
    vecs[3]  = '{3'b111, 1'b0, 3'b100, 1'b0};
    vecs[4]  = '{3'b111, 1'b0, 3'b001, 1'b0};
    vecs[5]  = '{3'b000, 1'b0, 3'b000, 1'b0};
    vecs[6]  = '{3'b010, 1'b1, 3'b000, 1'b1};
    vecs[7]  = '{3'b010, 1'b1, 3'b000, 1'b1};
    vecs[8]  = '{3'b010, 1'b1, 3'b000, 1'b1};
    vecs[9]  = '{3'b010, 1'b1, 3'b000, 1'b1};
    vecs[10] = '{3'b010, 1'b1, 3'b010, 1'b0};
    vecs[11] = '{3'b000, 1'b1, 3'b000, 1'b1};
    vecs[12] = '{3'b101, 1'b0, 3'b100, 1'b0};
    vecs[13] = '{3'b101, 1'b1, 3'b000, 1'b1};
    vecs[14] = '{3'b101, 1'b0, 3'b001, 1'b0};
    vecs[15] = '{3'b101, 1'b0, 3'b100, 1'b0};

    // Requests held during reset must not be granted.
    @(negedge clk);
    drive(3'b111, 1'b1);
    #1;
    check("reset_wr_ready", wr_ready, 3'b000);
    check("reset_rd_ready", rd_ready, 1'b0);
    check("reset_we3", rf_we3, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_state", {dbg_mode, dbg_rr_ptr, dbg_starve_cnt}, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(3'b000, 1'b0);

    // Round robin, read priority and starvation forcing.
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      drive(vecs[r].wv, vecs[r].rv);
      #1;
      check($sformatf("vec%0d_wr_ready", r), wr_ready, vecs[r].exp_wr);
      check($sformatf("vec%0d_rd_ready", r), rd_ready, vecs[r].exp_rd);
      check($sformatf("vec%0d_we3", r), rf_we3, |vecs[r].exp_wr);
    end

    // Load r5 then read it back with a2=r0.
    @(negedge clk);
    drive(3'b001, 1'b0);
    set_wr(0, 5'd5, 32'h1234);
    #1;
    check("t1_wr_ready", wr_ready, 3'b001);
    @(negedge clk);
    drive(3'b000, 1'b1);
    rd_a1 = 5'd5;
    rd_a2 = 5'd0;
    #1;
    check("t1_rd_ready", rd_ready, 1'b1);
    check("t1_rf_a1", rf_a1, 5'd5);
    @(negedge clk);
    drive(3'b000, 1'b0);
    #1;
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp_rd1", rsp_rd1, 32'h1234);
    check("t1_rsp_rd2", rsp_rd2, 32'h0);

    // Forced write of r7 while a read of r7 waits; read sees the new value.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(3'b001, 1'b1);
      set_wr(0, 5'd7, 32'hAA);
      rd_a1 = 5'd7;
      #1;
      check($sformatf("t4_read%0d", c), {wr_ready, rd_ready}, {3'b000, 1'b1});
    end
    @(negedge clk);
    drive(3'b001, 1'b1);
    set_wr(0, 5'd7, 32'hAA);
    rd_a1 = 5'd7;
    #1;
    check("t4_forced_mode", dbg_mode, 1'b1);
    check("t4_wr_grant", {wr_ready, rd_ready, rf_we3}, {3'b001, 1'b0, 1'b1});
    check("t4_rf_a3_wd3", {rf_a3, rf_wd3}, {5'd7, 32'hAA});
    check("t4_rf_a1_idle", rf_a1, 5'd0);
    @(negedge clk);
    drive(3'b000, 1'b1);
    rd_a1 = 5'd7;
    #1;
    check("t4_rd_grant", {rd_ready, rf_a1}, {1'b1, 5'd7});
    @(negedge clk);
    drive(3'b000, 1'b0);
    #1;
    check("t4_rsp", {rsp_valid, rsp_rd1}, {1'b1, 32'hAA});

    // Write to r0 is acknowledged but never enables the file.
    @(negedge clk);
    drive(3'b100, 1'b0);
    set_wr(2, 5'd0, 32'hFFFF);
    #1;
    check("t5_wr_ready", wr_ready, 3'b100);
    check("t5_we3", rf_we3, 1'b0);
    @(negedge clk);
    drive(3'b000, 1'b1);
    rd_a1 = 5'd0;
    @(negedge clk);
    drive(3'b000, 1'b0);
    #1;
    check("t5_r0_read", rsp_rd1, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset right after a read grant cancels the response.
    @(negedge clk);
    drive(3'b010, 1'b0);
    #1;
    check("t6_pre_write", wr_ready, 3'b010);
    @(negedge clk);
    drive(3'b000, 1'b1);
    #1;
    check("t6_rd_grant", rd_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    drive(3'b111, 1'b1);
    #1;
    check("t6_rsp_cancel", rsp_valid, 1'b0);
    check("t6_no_grant", {wr_ready, rd_ready, rf_we3}, 5'd0);
    check("t6_state", {dbg_mode, dbg_rr_ptr, dbg_starve_cnt}, 6'd0);
    @(negedge clk);
    #1;
    check("t6_hold_no_grant", {wr_ready, rd_ready, rsp_valid}, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(3'b000, 1'b0);
    #1;
    check("t6_after_release", {wr_ready, rd_ready, rsp_valid}, 5'd0);
    @(negedge clk);
    #1;
    check("t6_no_late_rsp", rsp_valid, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
